// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings up and supervises the board clock generator from the free-running
//   reference clock. It pulses the PLL reset, waits for lock with a timeout and
//   a bounded number of retries, then requires a run of consecutive lock
//   cycles before releasing the design-wide synchronous reset. Losing lock in
//   RUN, or a restart request, re-sequences the PLL from the start.
//
// Ports:
//   refclk        in   reference clock, the only clock of this block
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock, asynchronous to refclk (2-flop synchronized)
//   force_restart in   single-cycle restart request, synchronous to refclk
//   pll_rst       out  reset to the PLL primitive
//   sys_rst       out  synchronous active-high reset to the rest of the design
//   ready         out  clocks qualified (always ~sys_rst)
//   fail          out  lock retries exhausted
//   retry_cnt     out  retries used in the current bring-up
//   state_dbg     out  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
//   loss_cnt      out  count of lock losses seen in RUN
//
// Build option:
//   PLLSEQ_LOSS_COUNT_EN  when defined, loss_cnt counts RUN lock losses
//                         (saturating at 255, cleared only by rst); when not
//                         defined loss_cnt is tied to 0.
//
// Interface timing: there is no valid/ready handshake. force_restart is a
// level sampled on every refclk edge and acted on in whichever state it is
// seen; all outputs are registers that change on the same edge as the state.

module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_t      state;
  state_t      nxt_state;
  logic [23:0] cnt;
  logic [23:0] nxt_cnt;
  logic [23:0] cnt_inc;
  logic [3:0]  nxt_retry;
  logic        sync_meta;
  logic        locked_s;

  // Two-flop synchronizer; nothing downstream looks at pll_locked directly.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  // Counter saturates so a long stay in RUN or FAIL cannot wrap it.
  assign cnt_inc = (cnt == 24'hFF_FFFF) ? cnt : cnt + 24'd1;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt_inc;
    nxt_retry = retry_cnt;
    if (force_restart) begin
      nxt_state = S_RESET_PLL;
      nxt_cnt   = 24'd0;
      nxt_retry = 4'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = 24'd0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            nxt_state = S_STABLE;
            nxt_cnt   = 24'd0;
          end else if (cnt == LOCK_LAST) begin
            nxt_cnt = 24'd0;
            if (retry_cnt == RETRY_MAX) begin
              nxt_state = S_FAIL;
            end else begin
              nxt_state = S_RESET_PLL;
              nxt_retry = retry_cnt + 4'd1;
            end
          end
        end
        S_STABLE: begin
          // A drop wins over completion; the timeout restarts from zero.
          if (!locked_s) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = 24'd0;
          end else if (cnt == STABLE_LAST) begin
            nxt_state = S_RUN;
            nxt_cnt   = 24'd0;
            nxt_retry = 4'd0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            nxt_state = S_RESET_PLL;
            nxt_cnt   = 24'd0;
          end
        end
        S_FAIL: begin
          nxt_state = S_FAIL;
        end
        default: begin
          nxt_state = S_RESET_PLL;
          nxt_cnt   = 24'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as
  // the state register. pll_rst high implies sys_rst high in every state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= 24'd0;
      retry_cnt <= 4'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      retry_cnt <= nxt_retry;
      pll_rst   <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
      sys_rst   <= (nxt_state != S_RUN);
      ready     <= (nxt_state == S_RUN);
      fail      <= (nxt_state == S_FAIL);
    end
  end

  assign state_dbg = state;

`ifdef PLLSEQ_LOSS_COUNT_EN
  logic [7:0] loss_q;

  // Only a genuine lock loss in RUN counts; a restart request takes priority.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if ((state == S_RUN) && !force_restart && !locked_s &&
                 (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
